regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file, successor to the single-write/dual-read RF.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_clr_fsm.sv | 68 ++++++
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default data width and
// the encoding of the bulk-clear sequencer states.
package regfile_pkg;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;
endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks every clearable register once, then signals
// completion with a single-cycle done pulse.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          done_q;

  // Busy and done are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        CLR_IDLE: begin
          if (clr_req) begin
            state_q <= CLR_CLEAR;
            ptr_q   <= AW'(ZERO_REG);
            busy_q  <= 1'b1;
          end
        end
        CLR_CLEAR: begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= CLR_DONE;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        CLR_DONE: begin
          state_q <= CLR_IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= CLR_IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign clr_we   = (state_q == CLR_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NRD combinational
// read ports with optional same-cycle forwarding, and a sequential bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   RAddr_RF,
  output logic [NRD*XLEN-1:0] RD_RF,
  input  logic                WrEn0_RF,
  input  logic [AW-1:0]       WAddr0_RF,
  input  logic [XLEN-1:0]     WD0_RF,
  input  logic                WrEn1_RF,
  input  logic [AW-1:0]       WAddr1_RF,
  input  logic [XLEN-1:0]     WD1_RF,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            we0_eff;
  logic            we1_eff;

  regfile_clr_fsm #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Effective enables already exclude the clear window and the hardwired zero.
  assign we0_eff = WrEn0_RF && !clr_busy && !(ZERO_REG && (WAddr0_RF == '0));
  assign we1_eff = WrEn1_RF && !clr_busy && !(ZERO_REG && (WAddr1_RF == '0));

  // Port 1 is applied last so it overrides port 0 on an address collision.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
    end
    if (clr_we)  mem_d[clr_addr]  = '0;
    if (we0_eff) mem_d[WAddr0_RF] = WD0_RF;
    if (we1_eff) mem_d[WAddr1_RF] = WD1_RF;
    if (ZERO_REG) mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = RAddr_RF[i*AW +: AW];

    always_comb begin
      rd = mem_q[ra];
      if (ZERO_REG && (ra == '0)) begin
        rd = '0;
      end else if (BYPASS && we1_eff && (WAddr1_RF == ra)) begin
        rd = WD1_RF;
      end else if (BYPASS && we0_eff && (WAddr0_RF == ra)) begin
        rd = WD0_RF;
      end
    end

    assign RD_RF[i*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a ZERO_REG=0/BYPASS=0
// variant driven with identical stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        clr_req;

  logic [63:0] rd_a, rd_b;
  logic        busy_a, done_a, busy_b, done_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RAddr_RF  (raddr),
    .RD_RF     (rd_a),
    .WrEn0_RF  (we0),
    .WAddr0_RF (wa0),
    .WD0_RF    (wd0),
    .WrEn1_RF  (we1),
    .WAddr1_RF (wa1),
    .WD1_RF    (wd1),
    .clr_req   (clr_req),
    .clr_busy  (busy_a),
    .clr_done  (done_a)
  );

  regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_var (
    .clk       (clk),
    .rst_n     (rst_n),
    .RAddr_RF  (raddr),
    .RD_RF     (rd_b),
    .WrEn0_RF  (we0),
    .WAddr0_RF (wa0),
    .WD0_RF    (wd0),
    .WrEn1_RF  (we1),
    .WAddr1_RF (wa1),
    .WD1_RF    (wd1),
    .clr_req   (clr_req),
    .clr_busy  (busy_b),
    .clr_done  (done_b)
  );

  task automatic test_reset();
    rst_n = 1'b0; raddr = '0; we0 = 0; we1 = 0; wa0 = '0; wa1 = '0;
    wd0 = '0; wd1 = '0; clr_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    raddr = {5'd0, 5'd5};
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'h0) $display("FAIL reset_r5 got %h exp %h", rd_a[31:0], 32'h0);
    else pass_cnt++;
    total_cnt++;
    if ({busy_a, done_a} !== 2'b00) $display("FAIL reset_clr got %b exp 00", {busy_a, done_a});
    else pass_cnt++;
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    @(negedge clk);
    we0 = 0;
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'hDEADBEEF) $display("FAIL reset_pre_r5 got %h exp %h", rd_a[31:0], 32'hDEADBEEF);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'h0) $display("FAIL reset_async_r5 got %h exp %h", rd_a[31:0], 32'h0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we0 = 1; wa0 = 5'd3; wd0 = 32'h12345678;
    we1 = 1; wa1 = 5'd9; wd1 = 32'hCAFEF00D;
    raddr = {5'd9, 5'd3};
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'h12345678) $display("FAIL wr_bypass_p0 got %h exp %h", rd_a[31:0], 32'h12345678);
    else pass_cnt++;
    total_cnt++;
    if (rd_a[63:32] !== 32'hCAFEF00D) $display("FAIL wr_bypass_p1 got %h exp %h", rd_a[63:32], 32'hCAFEF00D);
    else pass_cnt++;
    total_cnt++;
    if (rd_b !== 64'h0) $display("FAIL wr_nobypass got %h exp %h", rd_b, 64'h0);
    else pass_cnt++;
    @(negedge clk);
    we0 = 0; we1 = 0;
    #1;
    total_cnt++;
    if (rd_a !== {32'hCAFEF00D, 32'h12345678}) $display("FAIL wr_read got %h exp %h", rd_a, {32'hCAFEF00D, 32'h12345678});
    else pass_cnt++;
    total_cnt++;
    if (rd_b !== {32'hCAFEF00D, 32'h12345678}) $display("FAIL wr_read_var got %h exp %h", rd_b, {32'hCAFEF00D, 32'h12345678});
    else pass_cnt++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    we0 = 1; wa0 = 5'd7; wd0 = 32'h1111;
    we1 = 1; wa1 = 5'd7; wd1 = 32'h2222;
    raddr = {5'd7, 5'd7};
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'h2222) $display("FAIL coll_bypass got %h exp %h", rd_a[31:0], 32'h2222);
    else pass_cnt++;
    @(negedge clk);
    we0 = 0; we1 = 0;
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'h2222) $display("FAIL coll_r7 got %h exp %h", rd_a[31:0], 32'h2222);
    else pass_cnt++;
    we0 = 1; wa0 = 5'd7; wd0 = 32'hAAAA;
    we1 = 1; wa1 = 5'd8; wd1 = 32'hBBBB;
    raddr = {5'd8, 5'd7};
    @(negedge clk);
    we0 = 0; we1 = 0;
    #1;
    total_cnt++;
    if (rd_a !== {32'hBBBB, 32'hAAAA}) $display("FAIL split_r7_r8 got %h exp %h", rd_a, {32'hBBBB, 32'hAAAA});
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    raddr = {5'd0, 5'd0};
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'h0) $display("FAIL zero_same got %h exp %h", rd_a[31:0], 32'h0);
    else pass_cnt++;
    @(negedge clk);
    we0 = 0;
    #1;
    total_cnt++;
    if (rd_a[31:0] !== 32'h0) $display("FAIL zero_after got %h exp %h", rd_a[31:0], 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (rd_b[31:0] !== 32'hFFFFFFFF) $display("FAIL zero_var got %h exp %h", rd_b[31:0], 32'hFFFFFFFF);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we0 = 1; wa0 = 5'(i); wd0 = 32'(i);
    end
    @(negedge clk);
    we0 = 0;
    raddr = {5'd2, 5'd31};
    #1;
    total_cnt++;
    if (rd_a !== {32'd2, 32'd31}) $display("FAIL fill got %h exp %h", rd_a, {32'd2, 32'd31});
    else pass_cnt++;
    clr_req = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      clr_req = (n == 15) || (n == 32);
      we0 = (n == 10); wa0 = 5'd2; wd0 = 32'h5555;
      raddr = {5'd20, 5'd2};
      #1;
      total_cnt++;
      if (busy_a !== (n <= 32)) $display("FAIL clr_busy n=%0d got %b exp %b", n, busy_a, (n <= 32));
      else pass_cnt++;
      total_cnt++;
      if (done_a !== (n == 32)) $display("FAIL clr_done n=%0d got %b exp %b", n, done_a, (n == 32));
      else pass_cnt++;
      if (n == 10) begin
        total_cnt++;
        if (rd_a !== {32'd20, 32'd0}) $display("FAIL clr_midread got %h exp %h", rd_a, {32'd20, 32'd0});
        else pass_cnt++;
      end
    end
    clr_req = 0; we0 = 0;
    for (int r = 0; r < 32; r++) begin
      raddr = {5'd0, 5'(r)};
      #1;
      total_cnt++;
      if (rd_a[31:0] !== 32'h0) $display("FAIL clr_zero r%0d got %h exp %h", r, rd_a[31:0], 32'h0);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    int busy_seen;
    int done_seen;
    int busy_cycles;
    int done_at;
    @(negedge clk);
    we0 = 1; wa0 = 5'd30; wd0 = 32'h30;
    @(negedge clk);
    we0 = 0;
    clr_req = 1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      clr_req = 0;
    end
    #1;
    total_cnt++;
    if (busy_a !== 1'b1) $display("FAIL abort_pre_busy got %b exp 1", busy_a);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    raddr = {5'd0, 5'd30};
    #1;
    total_cnt++;
    if ({busy_a, done_a} !== 2'b00) $display("FAIL abort_clr got %b exp 00", {busy_a, done_a});
    else pass_cnt++;
    total_cnt++;
    if (rd_a[31:0] !== 32'h0) $display("FAIL abort_r30 got %h exp %h", rd_a[31:0], 32'h0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0; done_seen = 0;
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      busy_seen += int'(busy_a);
      done_seen += int'(done_a);
    end
    total_cnt++;
    if (busy_seen != 0 || done_seen != 0) $display("FAIL abort_idle busy=%0d done=%0d exp 0/0", busy_seen, done_seen);
    else pass_cnt++;
    clr_req = 1;
    busy_cycles = 0; done_seen = 0; done_at = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      clr_req = 0;
      busy_cycles += int'(busy_a);
      if (done_a) begin
        done_seen++;
        done_at = n;
      end
    end
    total_cnt++;
    if (busy_cycles != 32) $display("FAIL rerun_busy got %0d exp 32", busy_cycles);
    else pass_cnt++;
    total_cnt++;
    if (done_seen != 1 || done_at != 32) $display("FAIL rerun_done got %0d@%0d exp 1@32", done_seen, done_at);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_zero_reg();
    test_clear();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
